// File: rtl/mips_mem_access_pkg.sv
// Shared types and helpers for the load/store bus unit.
// Holds the access-size and FSM-state codes and the byte-order swap.
package mips_mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUS,
        MEM_RESP
    } mem_state_t;

    // Core words are big-endian; the Avalon bus is little-endian by lane.
    function automatic logic [31:0] swap_endian(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the big-endian core and the little-endian Avalon lanes.
// Purely combinational: store enables/data, misalign detect, load extract and extend.
module mem_lane_align
    import mips_mem_access_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [15:0] w_st_half;
    logic [31:0] w_ld_lane;
    logic [15:0] w_ld_half;

    // Halfword store: lower lane takes the most significant byte.
    assign w_st_half = {i_st_wdata[7:0], i_st_wdata[15:8]};

    always_comb begin
        o_st_be      = 4'b0000;
        o_st_wdata   = 32'h0;
        o_misaligned = 1'b0;
        case (i_st_size)
            MEM_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr;
                o_st_wdata = {24'h0, i_st_wdata[7:0]} << {i_st_addr, 3'b000};
            end
            MEM_HALF: begin
                if (i_st_addr[0]) begin
                    o_misaligned = 1'b1;
                end else if (i_st_addr[1]) begin
                    o_st_be    = 4'b1100;
                    o_st_wdata = {w_st_half, 16'h0};
                end else begin
                    o_st_be    = 4'b0011;
                    o_st_wdata = {16'h0, w_st_half};
                end
            end
            MEM_WORD: begin
                if (i_st_addr != 2'b00) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_st_be    = 4'b1111;
                    o_st_wdata = swap_endian(i_st_wdata);
                end
            end
            default: o_misaligned = 1'b1;
        endcase
    end

    // Shift the addressed lane down to bit 0 before extracting.
    assign w_ld_lane = i_ld_rdata >> {i_ld_addr, 3'b000};
    assign w_ld_half = {w_ld_lane[7:0], w_ld_lane[15:8]};

    always_comb begin
        o_ld_data = 32'h0;
        case (i_ld_size)
            MEM_BYTE: begin
                o_ld_data = {{24{w_ld_lane[7] & ~i_ld_unsigned}}, w_ld_lane[7:0]};
            end
            MEM_HALF: begin
                o_ld_data = {{16{w_ld_half[15] & ~i_ld_unsigned}}, w_ld_half};
            end
            MEM_WORD: o_ld_data = swap_endian(i_ld_rdata);
            default:  o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mips_mem_access.sv
// Load/store bus unit: one core memory request at a time onto an Avalon-MM master,
// holding through waitrequest stalls and returning extended load data.
module mips_mem_access
    import mips_mem_access_pkg::*;
#(
    parameter int unsigned WAIT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic [WAIT_CNT_W-1:0] wait_cycles_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  waitrequest_i,
    output logic [31:0]           writedata_o,
    output logic [3:0]            byteenable_o,
    input  logic [31:0]           readdata_i
);

    mem_state_t            r_state;
    mem_state_t            w_state_next;
    logic                  w_accept;
    logic                  w_bus_done;

    logic                  r_we;
    logic [1:0]            r_size;
    logic [1:0]            r_addr_lo;
    logic                  r_unsigned;
    logic                  r_err;
    logic [31:0]           r_address;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic                  r_read;
    logic                  r_write;
    logic [31:0]           r_rdata;
    logic [WAIT_CNT_W-1:0] r_wait;

    logic [3:0]            w_st_be;
    logic [31:0]           w_st_wdata;
    logic                  w_misaligned;
    logic [31:0]           w_ld_data;

    mem_lane_align u_lane_align (
        .i_st_size     (req_size_i),
        .i_st_addr     (req_addr_i[1:0]),
        .i_st_wdata    (req_wdata_i),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .o_misaligned  (w_misaligned),
        .i_ld_size     (r_size),
        .i_ld_addr     (r_addr_lo),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (readdata_i),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bus_done   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (req_i) begin
                    w_accept     = 1'b1;
                    w_state_next = w_misaligned ? MEM_RESP : MEM_BUS;
                end
            end
            MEM_BUS: begin
                if (!waitrequest_i) begin
                    w_bus_done   = 1'b1;
                    w_state_next = MEM_RESP;
                end
            end
            MEM_RESP: w_state_next = MEM_IDLE;
            default:  w_state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_addr_lo  <= 2'b00;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_address  <= 32'h0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_rdata    <= 32'h0;
            r_wait     <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we_i;
                r_size     <= req_size_i;
                r_addr_lo  <= req_addr_i[1:0];
                r_unsigned <= req_unsigned_i;
                r_err      <= w_misaligned;
                r_wait     <= '0;
                // A misaligned request never touches the bus.
                if (!w_misaligned) begin
                    r_address <= {req_addr_i[31:2], 2'b00};
                    r_be      <= w_st_be;
                    r_wdata   <= w_st_wdata;
                    r_read    <= ~req_we_i;
                    r_write   <= req_we_i;
                end
            end
            if (r_state == MEM_BUS) begin
                if (waitrequest_i) begin
                    if (r_wait != '1) begin
                        r_wait <= r_wait + WAIT_CNT_W'(1);
                    end
                end
            end
            if (w_bus_done) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                if (!r_we) begin
                    r_rdata <= w_ld_data;
                end
            end
        end
    end

    assign busy_o        = (r_state != MEM_IDLE);
    assign done_o        = (r_state == MEM_RESP);
    assign err_o         = done_o & r_err;
    assign rdata_o       = r_rdata;
    assign wait_cycles_o = r_wait;
    assign address_o     = r_address;
    assign read_o        = r_read;
    assign write_o       = r_write;
    assign writedata_o   = r_wdata;
    assign byteenable_o  = r_be;

endmodule
